// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone BRAM arbiter: FSM states,
// master indices and bus widths.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int M_QSPI  = 0;
  localparam int M_AUX   = 1;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, on a tie the
// master named by rr_ptr wins. Purely combinational, one-hot result.
module rr_arb2
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = 2'b00;
      gnt[rr_ptr ? M_AUX : M_QSPI] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_bram_arb.sv
// Wishbone-classic two-master arbiter/controller for a single-port 1-cycle BRAM.
// Optional idle-lock timeout enabled by defining WBARB_TIMEOUT_EN.
module wb_bram_arb
  import wb_arb_pkg::*;
#(
  parameter int AW     = 9,
  parameter int DEPTH  = 512,
  parameter int TO_CYC = 255
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic [31:0]         m0_adr_i,
  input  logic                m0_we_i,
  input  logic [WB_SELW-1:0]  m0_sel_i,
  input  logic [WB_DW-1:0]    m0_dat_i,
  output logic [WB_DW-1:0]    m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic [31:0]         m1_adr_i,
  input  logic                m1_we_i,
  input  logic [WB_SELW-1:0]  m1_sel_i,
  input  logic [WB_DW-1:0]    m1_dat_i,
  output logic [WB_DW-1:0]    m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                mem_en,
  output logic [AW-1:0]       mem_addr,
  output logic [WB_SELW-1:0]  mem_we,
  output logic [WB_DW-1:0]    mem_din,
  input  logic [WB_DW-1:0]    mem_dout,
  output logic [1:0]          grant,
  output logic                timeout_o
);

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;
  logic               rd_q, rd_d;
  logic [WB_DW-1:0]   dat0_q, dat0_d;
  logic [WB_DW-1:0]   dat1_q, dat1_d;
  logic               timeout_q, timeout_d;
`ifdef WBARB_TIMEOUT_EN
  logic [7:0]         to_cnt_q, to_cnt_d;
`else
  logic [7:0]         unused_to_cyc;
  assign unused_to_cyc = 8'(TO_CYC);
`endif

  logic [1:0]         req, win;
  logic               own, own_cyc, own_stb, own_we, in_range;
  logic [31:0]        own_adr;
  logic [WB_SELW-1:0] own_sel;
  logic [WB_DW-1:0]   own_dat;
  logic [1:0]         unused_adr_lo;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (win)
  );

  // Owner mux defaults to master 0 when idle; mem_en gates every side effect.
  assign own      = grant_q[M_AUX];
  assign own_cyc  = own ? m1_cyc_i : m0_cyc_i;
  assign own_stb  = own ? m1_stb_i : m0_stb_i;
  assign own_we   = own ? m1_we_i  : m0_we_i;
  assign own_adr  = own ? m1_adr_i : m0_adr_i;
  assign own_sel  = own ? m1_sel_i : m0_sel_i;
  assign own_dat  = own ? m1_dat_i : m0_dat_i;
  assign in_range = ({2'b00, own_adr[31:2]} < 32'(DEPTH));
  assign unused_adr_lo = own_adr[1:0];

  assign mem_en   = (state_q == ST_XFER) & own_cyc & own_stb & in_range;
  assign mem_addr = own_adr[AW+1:2];
  assign mem_we   = {WB_SELW{own_we}} & own_sel & {WB_SELW{mem_en}};
  assign mem_din  = own_dat;

  // Read data comes straight from the BRAM while ack is up, then is held.
  assign m0_ack_o = ack_q[M_QSPI];
  assign m1_ack_o = ack_q[M_AUX];
  assign m0_err_o = err_q[M_QSPI];
  assign m1_err_o = err_q[M_AUX];
  assign m0_dat_o = (ack_q[M_QSPI] & rd_q) ? mem_dout : dat0_q;
  assign m1_dat_o = (ack_q[M_AUX] & rd_q) ? mem_dout : dat1_q;
  assign grant    = grant_q;
  assign timeout_o = timeout_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    rd_d      = rd_q;
    dat0_d    = dat0_q;
    dat1_d    = dat1_q;
    timeout_d = 1'b0;
`ifdef WBARB_TIMEOUT_EN
    to_cnt_d  = 8'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = win;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!own_cyc) begin
          state_d  = ST_IDLE;
          grant_d  = 2'b00;
          rr_ptr_d = ~own;
        end else if (own_stb) begin
          state_d = ST_RESP;
          rd_d    = ~own_we;
          if (in_range) ack_d = grant_q;
          else          err_d = grant_q;
        end else begin
`ifdef WBARB_TIMEOUT_EN
          if (to_cnt_q == 8'(TO_CYC - 1)) begin
            state_d   = ST_IDLE;
            grant_d   = 2'b00;
            rr_ptr_d  = ~own;
            timeout_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
`endif
        end
      end
      ST_RESP: begin
        if (ack_q[M_QSPI] & rd_q) dat0_d = mem_dout;
        if (ack_q[M_AUX] & rd_q)  dat1_d = mem_dout;
        if (own_cyc) begin
          state_d = ST_XFER;
        end else begin
          state_d  = ST_IDLE;
          grant_d  = 2'b00;
          rr_ptr_d = ~own;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_ptr_q  <= 1'b0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      rd_q      <= 1'b0;
      dat0_q    <= '0;
      dat1_q    <= '0;
      timeout_q <= 1'b0;
`ifdef WBARB_TIMEOUT_EN
      to_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      dat0_q    <= dat0_d;
      dat1_q    <= dat1_d;
      timeout_q <= timeout_d;
`ifdef WBARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

endmodule
